// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one 16-bit SRAM between instruction fetch
// and data memory; each 32-bit access runs as a low then high phase.
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic              o_if_ready,
  output logic [31:0]       o_if_data,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [31:0]       i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  input  logic [3:0]        i_dm_be,
  output logic              o_dm_ready,
  output logic [31:0]       o_dm_rdata,
  output logic              o_busy,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CMAX = CW'(WAIT_CYC - 1);

  // {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}
  localparam logic [5:0] STB_OFF = 6'b111110;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               gnt_dm;
  logic               last_dm;
  logic               we_q;
  logic [15:0]        wdata_hi_q;
  logic [1:0]         be_hi_q;
  logic [ADDR_W-1:0]  hi_addr_q;
  logic [15:0]        lo_q;

  logic               pick_dm;
  logic               sel_we;
  logic [31:0]        sel_word;
  logic [ADDR_W-1:0]  sel_lo_addr;
  logic [ADDR_W-1:0]  sel_hi_addr;
  logic               unused_ok;

  assign pick_dm     = i_dm_req & (~i_if_req | ~last_dm);
  assign sel_we      = pick_dm & i_dm_we;
  assign sel_word    = pick_dm ? {2'b00, i_dm_addr[31:2]} : i_if_addr;
  assign sel_lo_addr = ADDR_W'({sel_word, 1'b0});
  assign sel_hi_addr = ADDR_W'({sel_word, 1'b1});
  assign unused_ok   = &{1'b0, i_dm_addr[1:0]};

  // A write half with no byte enables leaves the chip deselected.
  function automatic logic [5:0] strb(input logic wr,
                                      input logic [1:0] en);
    logic act;
    act = |en;
    if (!wr) return 6'b001000;
    return {~act, 1'b1, ~act, ~en[0], ~en[1], act};
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt_dm       <= 1'b0;
      last_dm      <= 1'b0;
      we_q         <= 1'b0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
      hi_addr_q    <= '0;
      lo_q         <= '0;
      o_if_ready   <= 1'b0;
      o_dm_ready   <= 1'b0;
      o_if_data    <= '0;
      o_dm_rdata   <= '0;
      o_busy       <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      {o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
       o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe} <= STB_OFF;
    end else begin
      o_if_ready <= 1'b0;
      o_dm_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_if_req | i_dm_req) begin
            state       <= LO;
            o_busy      <= 1'b1;
            cnt         <= '0;
            gnt_dm      <= pick_dm;
            last_dm     <= pick_dm;
            we_q        <= sel_we;
            wdata_hi_q  <= i_dm_wdata[31:16];
            be_hi_q     <= i_dm_be[3:2];
            hi_addr_q   <= sel_hi_addr;
            o_sram_addr <= sel_lo_addr;
            if (sel_we) o_sram_dq <= i_dm_wdata[15:0];
            {o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
             o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}
              <= strb(sel_we, i_dm_be[1:0]);
          end
        end
        LO: begin
          if (cnt == CMAX) begin
            cnt         <= '0;
            state       <= HI;
            lo_q        <= i_sram_dq;
            o_sram_addr <= hi_addr_q;
            if (we_q) o_sram_dq <= wdata_hi_q;
            {o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
             o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}
              <= strb(we_q, be_hi_q);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HI: begin
          if (cnt == CMAX) begin
            cnt   <= '0;
            state <= DONE;
            {o_sram_ce_n, o_sram_oe_n, o_sram_we_n,
             o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe} <= STB_OFF;
            if (gnt_dm) o_dm_ready <= 1'b1;
            else        o_if_ready <= 1'b1;
            if (!we_q) begin
              if (gnt_dm) o_dm_rdata <= {i_sram_dq, lo_q};
              else        o_if_data  <= {i_sram_dq, lo_q};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table plus scoreboard on ready pulses,
// with hand sequences for strobes, arbitration, reset and WAIT_CYC=3.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load;
  logic        if_req, dm_req, dm_we, dm_req3;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  logic        if_ready, dm_ready, busy;
  logic [31:0] if_data, dm_rdata;
  logic        ce_n, oe_n, we_n, lb_n, ub_n, dq_oe;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq, sram_din;

  logic        if_ready3, dm_ready3, busy3;
  logic [31:0] if_data3, dm_rdata3;
  logic        ce3, oe3, we3, lb3, ub3, dqoe3;
  logic [19:0] addr3;
  logic [15:0] dq3, din3;

  logic [15:0] mem [0:255];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  sram_arbiter #(.ADDR_W(20), .WAIT_CYC(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ready(if_ready), .o_if_data(if_data),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
    .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata), .o_busy(busy),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n), .o_sram_addr(sram_addr),
    .o_sram_dq(sram_dq), .o_sram_dq_oe(dq_oe), .i_sram_dq(sram_din)
  );

  sram_arbiter #(.ADDR_W(20), .WAIT_CYC(3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(1'b0), .i_if_addr(32'd0),
    .o_if_ready(if_ready3), .o_if_data(if_data3),
    .i_dm_req(dm_req3), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
    .o_dm_ready(dm_ready3), .o_dm_rdata(dm_rdata3), .o_busy(busy3),
    .o_sram_ce_n(ce3), .o_sram_oe_n(oe3), .o_sram_we_n(we3),
    .o_sram_lb_n(lb3), .o_sram_ub_n(ub3), .o_sram_addr(addr3),
    .o_sram_dq(dq3), .o_sram_dq_oe(dqoe3), .i_sram_dq(din3)
  );

  assign sram_din = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0BAD;
  assign din3 = (!ce3 && !oe3) ?
                ((addr3 == 20'd0) ? 16'h3210 :
                 (addr3 == 20'd1) ? 16'h7654 : 16'hEEEE) : 16'h0BAD;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 10) ? 16'hBEEF :
                  (i == 11) ? 16'hDEAD : 16'hA000 + 16'(i);
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (if_ready || dm_ready) begin
      if (sbq.size() == 0) begin
        chk("unexp_ready", {30'd0, if_ready, dm_ready}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ready_port", {30'd0, if_ready, dm_ready},
            mon_e.is_dm ? 32'd1 : 32'd2);
        chk("ready_data", mon_e.is_dm ? dm_rdata : if_data, mon_e.data);
        chk("ready_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic push(input logic d, input logic [31:0] v, input int at);
    exp_t e;
    e.is_dm = d;
    e.data  = v;
    e.at    = at;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("sb_drain", sbq.size(), 32'd0);
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  task automatic run_txn(input vec_t v);
    wait_idle();
    if (v.is_dm) begin
      dm_req   = 1'b1;
      dm_we    = v.we;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      dm_be    = v.be;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    push(v.is_dm, v.exp, cyc + 3);
    @(negedge clk);
    if_req = 1'b0;
    dm_req = 1'b0;
    wait_sb();
  endtask

  vec_t vt [11];
  int   c0;

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32'd5,        32'd0,         4'h0, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 1'b0, 32'h18,       32'd0,         4'h0, 32'hA00DA00C};
    vt[2]  = '{1'b1, 1'b1, 32'h18,       32'h12345678,  4'h3, 32'hA00DA00C};
    vt[3]  = '{1'b1, 1'b0, 32'h18,       32'd0,         4'h0, 32'hA00D5678};
    vt[4]  = '{1'b1, 1'b1, 32'h20,       32'hCAFEF00D,  4'hF, 32'hA00D5678};
    vt[5]  = '{1'b1, 1'b0, 32'h20,       32'd0,         4'h0, 32'hCAFEF00D};
    vt[6]  = '{1'b1, 1'b1, 32'h20,       32'hAB000000,  4'h8, 32'hCAFEF00D};
    vt[7]  = '{1'b0, 1'b0, 32'd8,        32'd0,         4'h0, 32'hABFEF00D};
    vt[8]  = '{1'b0, 1'b0, 32'h00080005, 32'd0,         4'h0, 32'hDEADBEEF};
    vt[9]  = '{1'b1, 1'b1, 32'h24,       32'h00770000,  4'h4, 32'hCAFEF00D};
    vt[10] = '{1'b1, 1'b0, 32'h24,       32'd0,         4'h0, 32'hA077A012};

    rst_n = 1'b0; load = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; dm_req3 = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    repeat (3) @(negedge clk);
    load = 1'b0;

    chk("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_busy", {30'd0, busy, busy3}, 32'd0);
    chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_addr", {12'd0, sram_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vt[i]);

    // IF read strobes and addresses
    wait_idle();
    if_req = 1'b1; if_addr = 32'd5;
    push(1'b0, 32'hDEADBEEF, cyc + 3);
    @(negedge clk);
    if_req = 1'b0;
    chk("if_lo_addr", {12'd0, sram_addr}, 32'd10);
    chk("if_lo_stb", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h08);
    @(negedge clk);
    chk("if_hi_addr", {12'd0, sram_addr}, 32'd11);
    chk("if_hi_stb", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h08);
    wait_sb();

    // DM write with only the low half enabled
    wait_idle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h18;
    dm_wdata = 32'h11112222; dm_be = 4'b0011;
    push(1'b1, 32'hA077A012, cyc + 3);
    @(negedge clk);
    dm_req = 1'b0;
    chk("wr_lo_addr", {12'd0, sram_addr}, 32'd12);
    chk("wr_lo_stb", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h11);
    chk("wr_lo_dq", {16'd0, sram_dq}, 32'h2222);
    @(negedge clk);
    chk("wr_hi_addr", {12'd0, sram_addr}, 32'd13);
    chk("wr_hi_off", {29'd0, ce_n, we_n, dq_oe}, 32'h6);
    wait_sb();
    chk("mem12", {16'd0, mem[12]}, 32'h2222);
    chk("mem13", {16'd0, mem[13]}, 32'hA00D);

    // both requesters held from reset: DM first, then alternate
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'd3;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    @(negedge clk);
    chk("arb_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    c0 = cyc;
    push(1'b1, 32'hA009A008, c0 + 3);
    push(1'b0, 32'hA007A006, c0 + 7);
    push(1'b1, 32'hA009A008, c0 + 11);
    push(1'b0, 32'hA007A006, c0 + 15);
    wait_sb();
    if_req = 1'b0;
    dm_req = 1'b0;

    // reset during the high phase of a write
    wait_idle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h28;
    dm_wdata = 32'h55556666; dm_be = 4'hF;
    @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk);
    chk("mid_hi_addr", {12'd0, sram_addr}, 32'd21);
    chk("mid_hi_we", {31'd0, we_n}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_strobes", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe}, 32'h3E);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    chk("mid_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1;
    chk("mid_mem20", {16'd0, mem[20]}, 32'h6666);
    repeat (5) @(negedge clk);

    // WAIT_CYC = 3 read of word 0
    dm_addr = 32'd0; dm_we = 1'b0; dm_be = 4'h0;
    dm_req3 = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      dm_req3 = 1'b0;
      if (k <= 6) begin
        chk("w3_addr", {12'd0, addr3}, (k <= 3) ? 32'd0 : 32'd1);
        chk("w3_oe_ce", {30'd0, oe3, ce3}, 32'd0);
        chk("w3_ready_early", {31'd0, dm_ready3}, 32'd0);
      end else begin
        chk("w3_ready", {31'd0, dm_ready3}, 32'd1);
        chk("w3_cycle", cyc, c0 + 7);
        chk("w3_data", dm_rdata3, 32'h76543210);
      end
    end
    @(negedge clk);
    chk("w3_ready_pulse", {31'd0, dm_ready3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
